fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 25 ++
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and types for the instruction fetch controller.
//   XLEN / BIOS_AW / IMEM_AW : PC and memory word-address widths
//   BIOS_SEL_BIT             : PC bit selecting BIOS (1) or IMEM (0)
//   NOP_INST                 : bubble instruction (addi x0,x0,0)
//   RESET_PC_DEFAULT         : default first fetch address
//   fetch_state_e            : fetch FSM states
package fetch_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned BIOS_AW      = 12;
  localparam int unsigned IMEM_AW      = 14;
  localparam int unsigned BIOS_SEL_BIT = 30;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h4000_0000;

  // BUBBLE: nothing valid presented; RUN: live memory data presented;
  // HOLD: a stalled instruction replayed from the hold register.
  typedef enum logic [1:0] {
    BUBBLE = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: pipeline control in, memory ports, decode-side
// instruction out.
//   master : the fetch controller side
//   slave  : the surrounding pipeline / memories side
//   stall, redirect_valid, redirect_pc : pipeline control
//   bios_addr, bios_dout, imem_addr, imem_dout : synchronous-read memories
//   inst, inst_pc, inst_valid : instruction presented to decode
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic                stall;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic [BIOS_AW-1:0]  bios_addr;
  logic [IMEM_AW-1:0]  imem_addr;
  logic [XLEN-1:0]     bios_dout;
  logic [XLEN-1:0]     imem_dout;
  logic [XLEN-1:0]     inst;
  logic [XLEN-1:0]     inst_pc;
  logic                inst_valid;

  modport master (
    input  stall, redirect_valid, redirect_pc, bios_dout, imem_dout,
    output bios_addr, imem_addr, inst, inst_pc, inst_valid
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, bios_dout, imem_dout,
    input  bios_addr, imem_addr, inst, inst_pc, inst_valid
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word addresses to BIOS and IMEM
// (both 1-cycle synchronous read), muxes the returning word by the source of
// its own address, holds the presented instruction across stalls and inserts
// a single bubble after each redirect.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   ifc  : fetch_ctrl_if.master (control in, memory ports, inst/inst_pc/inst_valid out)
// Outputs depend only on registered state and the memory read data.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  ifc
);
  import fetch_pkg::*;

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  inst_pc_q, inst_pc_d;
  logic             src_bios_q, src_bios_d;
  logic [XLEN-1:0]  hold_inst_q, hold_inst_d;

  logic [XLEN-1:0]  live_inst_c;
  logic [XLEN-1:0]  redirect_tgt_c;
  logic [XLEN-1:0]  inst_c;
  logic             inst_valid_c;

  // Word returning this cycle, selected by the source of the address that fetched it
  assign live_inst_c    = src_bios_q ? ifc.bios_dout : ifc.imem_dout;
  assign redirect_tgt_c = ifc.redirect_pc & 32'hFFFF_FFFC;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BUBBLE;
      fetch_pc_q  <= RESET_PC;
      inst_pc_q   <= RESET_PC;
      src_bios_q  <= RESET_PC[BIOS_SEL_BIT];
      hold_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      inst_pc_q   <= inst_pc_d;
      src_bios_q  <= src_bios_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  // Next state: redirect beats stall; stall freezes everything except RUN->HOLD capture
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    inst_pc_d   = inst_pc_q;
    src_bios_d  = src_bios_q;
    hold_inst_d = hold_inst_q;

    if (ifc.redirect_valid) begin
      // In-flight and held words are dropped; target is issued next cycle from BUBBLE
      state_d     = BUBBLE;
      fetch_pc_d  = redirect_tgt_c;
      src_bios_d  = fetch_pc_q[BIOS_SEL_BIT];
      hold_inst_d = NOP_INST;
    end else if (!ifc.stall) begin
      // The memory samples fetch_pc on this edge, so its select travels with it
      state_d    = RUN;
      fetch_pc_d = fetch_pc_q + 32'd4;
      inst_pc_d  = fetch_pc_q;
      src_bios_d = fetch_pc_q[BIOS_SEL_BIT];
    end else begin
      case (state_q)
        RUN: begin
          // fetch_pc is frozen, so next cycle's read data is not this word: keep a copy
          state_d     = HOLD;
          hold_inst_d = live_inst_c;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Presented instruction
  always_comb begin
    inst_c       = NOP_INST;
    inst_valid_c = 1'b0;
    case (state_q)
      RUN: begin
        inst_c       = live_inst_c;
        inst_valid_c = 1'b1;
      end
      HOLD: begin
        inst_c       = hold_inst_q;
        inst_valid_c = 1'b1;
      end
      default: begin
        inst_c       = NOP_INST;
        inst_valid_c = 1'b0;
      end
    endcase
  end

  assign ifc.bios_addr  = fetch_pc_q[BIOS_AW+1:2];
  assign ifc.imem_addr  = fetch_pc_q[IMEM_AW+1:2];
  assign ifc.inst       = inst_c;
  assign ifc.inst_valid = inst_valid_c;
  assign ifc.inst_pc    = inst_pc_q;

endmodule
